// File: rtl/rom_boot_copier.sv
// ROM boot copier: bus master that reads a run of consecutive ROM words
// and forwards each one to a downstream sink over a valid/ready stream.
// All outputs are registered and decoded from the next state.
module rom_boot_copier #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cs_n,
  output logic              as_n,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rdy_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   out_index,
  output logic [DATA_W-1:0] out_data
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   TMO_ONE  = CW'(1);
  localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {IDLE, REQ, PUSH, DONE, ERR} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   base, base_nx;
  logic [ADDR_W:0]     cnt, cnt_nx;
  logic [ADDR_W:0]     idx, idx_nx;
  logic [CW-1:0]       tmo, tmo_nx;
  logic                cap;
  logic                err_clr;

  // Next-state logic and datapath updates for the transfer sequencer.
  always_comb begin
    state_nx = state;
    base_nx  = base;
    cnt_nx   = cnt;
    idx_nx   = idx;
    tmo_nx   = tmo;
    cap      = 1'b0;
    err_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          base_nx  = src_base;
          cnt_nx   = word_count;
          idx_nx   = '0;
          tmo_nx   = '0;
          err_clr  = 1'b1;
          state_nx = (word_count == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (!rdy_n) begin
          // Ready wins over a timeout landing on the same edge.
          cap      = 1'b1;
          tmo_nx   = '0;
          state_nx = PUSH;
        end else if (tmo == TMO_LAST) begin
          tmo_nx   = '0;
          state_nx = ERR;
        end else begin
          tmo_nx   = tmo + TMO_ONE;
        end
      end
      PUSH: begin
        if (out_ready) begin
          idx_nx   = idx + IDX_ONE;
          state_nx = ((idx + IDX_ONE) == cnt) ? DONE : REQ;
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      base      <= '0;
      cnt       <= '0;
      idx       <= '0;
      tmo       <= '0;
      cs_n      <= 1'b1;
      as_n      <= 1'b1;
      addr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_nx;
      base      <= base_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      tmo       <= tmo_nx;
      cs_n      <= (state_nx != REQ);
      as_n      <= (state_nx != REQ);
      busy      <= (state_nx == REQ) || (state_nx == PUSH);
      done      <= (state_nx == DONE);
      out_valid <= (state_nx == PUSH);
      // Address is computed once on entry to REQ and held for the whole request.
      if (state_nx == REQ && state != REQ)
        addr <= base_nx + idx_nx[ADDR_W-1:0];
      if (cap) begin
        out_data  <= rd_data;
        out_index <= idx;
      end
      if (err_clr)
        error <= 1'b0;
      else if (state_nx == ERR)
        error <= 1'b1;
    end
  end

endmodule
